rcc_lsecss_monitor: RTL and testbench



---
 rtl/rcc_pkg.sv | 14 +
 rtl/rcc_sync_edge_det.sv | 25 ++
 rtl/rcc_lsecss_monitor.sv | 114 +++++++++++
 tb/tb_rcc_lsecss_monitor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rcc_pkg.sv
// Shared RCC definitions: LSE clock-security state encoding and default monitor constants.
package rcc_pkg;

  typedef enum logic [1:0] {
    LSECSS_IDLE    = 2'd0,
    LSECSS_ARM     = 2'd1,
    LSECSS_MONITOR = 2'd2,
    LSECSS_FAIL    = 2'd3
  } lsecss_state_e;

  localparam int unsigned LSECSS_TIMEOUT_CYC = 16;
  localparam int unsigned LSECSS_ARM_EDGES   = 2;

endpackage

// File: rtl/rcc_sync_edge_det.sv
// N-flop synchroniser plus history flop; flags any level change of an asynchronous toggle.
// Shared by the LSE and HSE clock-security monitors.
module rcc_sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tog_i,
  output logic edge_c_o
);

  // sync_q[0] is the first synchroniser flop, sync_q[STAGES] is the history flop
  logic [STAGES:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-1:0], tog_i};
    end
  end

  assign edge_c_o = sync_q[STAGES] ^ sync_q[STAGES-1];

endmodule

// File: rtl/rcc_lsecss_monitor.sv
// LSE clock security monitor: declares sticky LSE failure when the divided LSE toggle goes silent.
// Define RCC_LSECSS_SYNC3_EN for a 3-flop synchroniser instead of the default 2-flop one.
module rcc_lsecss_monitor
  import rcc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = LSECSS_TIMEOUT_CYC,
  parameter int unsigned ARM_EDGES   = LSECSS_ARM_EDGES
) (
  input  logic       lsi_clk,
  input  logic       vsw_rst,
  input  logic       lsecsson,
  input  logic       lse_rdy,
  input  logic       lse_div_tog,
  input  logic       testmode,
  output logic       lsecss_fail,
  output logic       lsecss_int,
  output logic [1:0] lsecss_state
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
`ifdef RCC_LSECSS_SYNC3_EN
  localparam int unsigned SYNC_STAGES = 3;
`else
  localparam int unsigned SYNC_STAGES = 2;
`endif

  localparam logic [CNT_W-1:0] SIL_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] SIL_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       ARM_LAST = 4'(ARM_EDGES - 1);

  logic          tog_edge_c;
  lsecss_state_e state_q, state_d;
  logic [CNT_W-1:0] sil_cnt_q, sil_cnt_d;
  logic [3:0]    edge_cnt_q, edge_cnt_d;
  logic          fail_q, fail_d;
  logic          int_q, int_d;

  rcc_sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_i    (lsi_clk),
    .rst_i    (vsw_rst),
    .tog_i    (lse_div_tog),
    .edge_c_o (tog_edge_c)
  );

  // Next-state, counter and output decode
  always_comb begin
    state_d    = state_q;
    sil_cnt_d  = sil_cnt_q;
    edge_cnt_d = '0;

    if (state_q == LSECSS_IDLE || tog_edge_c) begin
      sil_cnt_d = '0;
    end else if (sil_cnt_q != SIL_MAX) begin
      sil_cnt_d = sil_cnt_q + CNT_W'(1);
    end

    if (state_q == LSECSS_ARM) begin
      edge_cnt_d = tog_edge_c ? edge_cnt_q + 4'd1 : edge_cnt_q;
    end

    case (state_q)
      LSECSS_IDLE: begin
        if (lsecsson && lse_rdy) state_d = LSECSS_ARM;
      end
      LSECSS_ARM: begin
        if (!lsecsson || !lse_rdy) begin
          state_d = LSECSS_IDLE;
        end else if (tog_edge_c && edge_cnt_q == ARM_LAST) begin
          state_d = LSECSS_MONITOR;
        end
      end
      LSECSS_MONITOR: begin
        // >= so a counter saturated under testmode fails as soon as testmode drops
        if (!lsecsson) begin
          state_d = LSECSS_IDLE;
        end else if (!tog_edge_c && sil_cnt_q >= SIL_LAST && !testmode) begin
          state_d = LSECSS_FAIL;
        end
      end
      LSECSS_FAIL: begin
        state_d = LSECSS_FAIL;
      end
      default: begin
        state_d = LSECSS_IDLE;
      end
    endcase

    fail_d = (state_d == LSECSS_FAIL);
    int_d  = (state_d == LSECSS_FAIL) && (state_q != LSECSS_FAIL);
  end

  always_ff @(posedge lsi_clk or posedge vsw_rst) begin
    if (vsw_rst) begin
      state_q    <= LSECSS_IDLE;
      sil_cnt_q  <= '0;
      edge_cnt_q <= '0;
      fail_q     <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sil_cnt_q  <= sil_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      fail_q     <= fail_d;
      int_q      <= int_d;
    end
  end

  assign lsecss_fail  = fail_q;
  assign lsecss_int   = int_q;
  assign lsecss_state = 2'(state_q);

endmodule

// File: tb/tb_rcc_lsecss_monitor.sv
// Directed scoreboard bench for rcc_lsecss_monitor (honours RCC_LSECSS_SYNC3_EN for edge latency).
module tb_rcc_lsecss_monitor;

`ifdef RCC_LSECSS_SYNC3_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       lsi_clk     = 1'b0;
  logic       vsw_rst     = 1'b1;
  logic       lsecsson    = 1'b0;
  logic       lse_rdy     = 1'b0;
  logic       lse_div_tog = 1'b0;
  logic       testmode    = 1'b0;
  logic       lsecss_fail;
  logic       lsecss_int;
  logic [1:0] lsecss_state;

  typedef struct {
    string      tag;
    logic       f;
    logic       i;
    logic [1:0] s;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  rcc_lsecss_monitor dut (
    .lsi_clk      (lsi_clk),
    .vsw_rst      (vsw_rst),
    .lsecsson     (lsecsson),
    .lse_rdy      (lse_rdy),
    .lse_div_tog  (lse_div_tog),
    .testmode     (testmode),
    .lsecss_fail  (lsecss_fail),
    .lsecss_int   (lsecss_int),
    .lsecss_state (lsecss_state)
  );

  always #5 lsi_clk = ~lsi_clk;

  task automatic push(input string tag, input logic f, input logic i, input logic [1:0] s);
    exp_t e;
    e.tag = tag; e.f = f; e.i = i; e.s = s;
    sb.push_back(e);
  endtask

  task automatic compare_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert ({lsecss_fail, lsecss_int, lsecss_state} === {e.f, e.i, e.s})
      else begin
        failures++;
        $error("FAIL %s: got fail=%0b int=%0b state=%0d, want fail=%0b int=%0b state=%0d",
               e.tag, lsecss_fail, lsecss_int, lsecss_state, e.f, e.i, e.s);
      end
    end
  endtask

  task automatic tick();
    @(posedge lsi_clk);
    #1;
  endtask

  task automatic step(input string tag, input logic f, input logic i, input logic [1:0] s);
    push(tag, f, i, s);
    tick();
    compare_all();
  endtask

  task automatic toggle_for(input string tag, input int n, input int period, input bit chk,
                            input logic f, input logic [1:0] s);
    for (int k = 0; k < n; k++) begin
      if (k % period == 0) lse_div_tog = ~lse_div_tog;
      if (chk) push(tag, f, 1'b0, s);
      tick();
      compare_all();
    end
  endtask

  task automatic do_reset();
    vsw_rst     = 1'b1;
    lse_div_tog = 1'b0;
    tick();
    tick();
    vsw_rst = 1'b0;
  endtask

  task automatic rearm();
    do_reset();
    lsecsson = 1'b1;
    lse_rdy  = 1'b1;
    testmode = 1'b0;
    step("arm_entry", 1'b0, 1'b0, 2'd1);
    toggle_for("arming", 40, 4, 1'b0, 1'b0, 2'd0);
    step("monitor_entry", 1'b0, 1'b0, 2'd2);
  endtask

  // Final toggle, then silence: fail/int must rise exactly LAT+16 clocks after the toggle
  task automatic last_toggle_then_fail(input string tag);
    lse_div_tog = ~lse_div_tog;
    for (int k = 0; k < LAT + 15; k++) step({tag, "_pre"}, 1'b0, 1'b0, 2'd2);
    step({tag, "_rise"}, 1'b1, 1'b1, 2'd3);
    step({tag, "_held"}, 1'b1, 1'b0, 2'd3);
  endtask

  initial begin
    step("reset_state", 1'b0, 1'b0, 2'd0);

    // Arm, then healthy LSE toggling every 4 cycles
    rearm();
    toggle_for("t1_healthy", 1000, 4, 1'b1, 1'b0, 2'd2);

    // Toggle stops: failure and one-cycle interrupt
    last_toggle_then_fail("t2_stop");
    for (int k = 0; k < 200; k++) step("t2_sticky", 1'b1, 1'b0, 2'd3);

    // FAIL ignores enable, ready and resumed toggles; async reset clears mid-cycle
    lsecsson = 1'b0;
    lse_rdy  = 1'b0;
    toggle_for("t5_fail_sticky", 20, 3, 1'b1, 1'b1, 2'd3);
    #3;
    vsw_rst = 1'b1;
    #1;
    push("t5_async_reset", 1'b0, 1'b0, 2'd0);
    compare_all();
    step("t5_reset_held", 1'b0, 1'b0, 2'd0);
    vsw_rst     = 1'b0;
    lse_div_tog = 1'b0;
    step("t5_idle_after", 1'b0, 1'b0, 2'd0);
    step("t5_idle_stays", 1'b0, 1'b0, 2'd0);

    // Edge exactly in the sil_cnt==TIMEOUT-1 cycle wins over timeout
    rearm();
    toggle_for("t3_boundary", 160, 16, 1'b1, 1'b0, 2'd2);
    last_toggle_then_fail("t3_stop");

    // testmode blocks failure; release fails on the next edge from a saturated counter
    rearm();
    testmode = 1'b1;
    for (int k = 0; k < 100; k++) step("t4_testmode", 1'b0, 1'b0, 2'd2);
    testmode = 1'b0;
    step("t4_release", 1'b1, 1'b1, 2'd3);
    testmode = 1'b1;
    step("t4_fail_in_tm", 1'b1, 1'b0, 2'd3);
    testmode = 1'b0;

    // lse_rdy drop ignored in MONITOR; lsecsson drop in the timeout cycle wins
    rearm();
    lse_rdy = 1'b0;
    toggle_for("t7_rdy_ignored", 40, 4, 1'b1, 1'b0, 2'd2);
    lse_div_tog = ~lse_div_tog;
    for (int k = 0; k < LAT + 15; k++) step("t7_pre", 1'b0, 1'b0, 2'd2);
    lsecsson = 1'b0;
    step("t7_off_at_timeout", 1'b0, 1'b0, 2'd0);

    // ARM never times out; lse_rdy drop returns to IDLE
    do_reset();
    lsecsson = 1'b1;
    lse_rdy  = 1'b1;
    step("t6_arm", 1'b0, 1'b0, 2'd1);
    for (int k = 0; k < 50; k++) step("t6_arm_silent", 1'b0, 1'b0, 2'd1);
    lse_rdy = 1'b0;
    step("t6_rdy_drop", 1'b0, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
